// File: rtl/imm_ext_pipe_pkg.sv
// Shared immediate-format encodings and the combinational extension function
// used by the decode-stage immediate extender.
package imm_pkg;

  localparam int unsigned INSTR_W   = 25;
  localparam int unsigned IMM_MAX_W = 64;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_src_t;

  // Result at the widest supported XLEN; narrower users keep the low bits.
  typedef struct packed {
    logic                 err;
    logic [IMM_MAX_W-1:0] imm;
  } imm_ext_t;

  // instr holds instruction bits [31:7]; bit 24 is the sign bit.
  function automatic imm_ext_t imm_extend(input logic [INSTR_W-1:0] instr,
                                          input imm_src_t           src,
                                          input int unsigned        xlen);
    imm_ext_t r;
    logic     s;
    r = '0;
    s = instr[24];
    case (src)
      IMM_I:  r.imm = {{52{s}}, instr[24:13]};
      IMM_S:  r.imm = {{52{s}}, instr[24:18], instr[4:0]};
      IMM_B:  r.imm = {{51{s}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_U:  r.imm = {{32{s}}, instr[24:5], 12'b0};
      IMM_J:  r.imm = {{43{s}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_Z:  r.imm = {59'b0, instr[12:8]};
      IMM_SH: r.imm = (xlen == 64) ? {58'b0, instr[18:13]} : {59'b0, instr[17:13]};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_ext_pipe_skid_buf.sv
// Two-entry valid/ready buffer: output register plus skid register, with a
// registered in_ready so upstream never sees a combinational ready path.
module imm_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         or_valid_q, or_valid_d;
  logic [W-1:0] or_data_q,  or_data_d;
  logic         sk_valid_q, sk_valid_d;
  logic [W-1:0] sk_data_q,  sk_data_d;
  logic         rdy_q,      rdy_d;
  logic         accept_c;
  logic         or_free_c;

  assign accept_c  = in_valid & rdy_q;
  assign or_free_c = ~or_valid_q | out_ready;

  // Refill OR from SK first so beats leave in arrival order.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    if (or_free_c) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        sk_valid_d = accept_c;
        if (accept_c) begin
          sk_data_d = in_data;
        end
      end else begin
        or_valid_d = accept_c;
        if (accept_c) begin
          or_data_d = in_data;
        end
      end
    end else if (accept_c) begin
      sk_valid_d = 1'b1;
      sk_data_d  = in_data;
    end
    rdy_d = ~sk_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined decode-stage immediate extender: combinational format decode
// registered into a two-entry skid buffer together with error flag and tag.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_imm_src,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic               out_err,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned PW = 1 + TAG_W + XLEN;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  imm_ext_t        ext_c;
  logic            unused_imm_c;
  logic [PW-1:0]   in_pl_c;
  logic [PW-1:0]   out_pl_c;

  assign ext_c   = imm_extend(in_instr, imm_src_t'(in_imm_src), XLEN);
  assign in_pl_c = {ext_c.err, in_tag, ext_c.imm[XLEN-1:0]};

  // Bits above XLEN only repeat the sign or are zero when XLEN=32.
  assign unused_imm_c = ^ext_c.imm;

  imm_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl_c)
  );

  assign {out_err, out_tag, out_imm} = out_pl_c;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: XLEN=32 and XLEN=64 instances share
// stimulus and are compared against an instruction-level reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  imm_ext_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_err(out_err32), .out_tag(out_tag32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_err(out_err64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  bit mon_en = 0;
  bit thr_mode = 0;
  bit rdy_low  = 0;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic        err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] seen[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [63:0] v, input int n);
    longint t;
    t = longint'(v << (64 - n));
    return t >>> (64 - n);
  endfunction

  // Reference: rebuild the 32-bit instruction and pick RISC-V immediate fields.
  function automatic longint model(input logic [24:0] i25, input logic [2:0] src, input int xlen);
    logic [31:0] inst;
    inst = {i25, 7'b0};
    case (src)
      3'd0: return sx(64'(inst[31:20]), 12);
      3'd1: return sx(64'({inst[31:25], inst[11:7]}), 12);
      3'd2: return sx(64'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
      3'd3: return sx(64'({inst[31:12], 12'b0}), 32);
      3'd4: return sx(64'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
      3'd5: return longint'(inst[19:15]);
      3'd6: return (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
      default: return 0;
    endcase
  endfunction

  // Checks both instances every cycle, then applies the coming edge's transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t   e;
      longint m;
      logic   drain, accept;
      chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
      chk("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
      chk("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
      if (out_valid32 && q.size() != 0) begin
        chk("imm32", 64'(out_imm32), 64'(q[0].imm32));
        chk("err32", 64'(out_err32), 64'(q[0].err));
        chk("tag32", 64'(out_tag32), 64'(q[0].tag));
        chk("imm64", out_imm64,      q[0].imm64);
        chk("err64", 64'(out_err64), 64'(q[0].err));
        chk("tag64", 64'(out_tag64), 64'(q[0].tag));
      end
      if (thr_mode && !in_ready32) rdy_low = 1;
      drain  = out_valid32 && out_ready;
      accept = in_valid && in_ready32;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (drain && q.size() != 0) begin
          seen.push_back(q[0].tag);
          void'(q.pop_front());
          n_out++;
        end
        if (accept) begin
          e.tag   = in_tag;
          e.err   = (in_imm_src == 3'd7);
          e.imm64 = 64'(model(in_instr, in_imm_src, 64));
          m       = model(in_instr, in_imm_src, 32);
          e.imm32 = 32'(m);
          q.push_back(e);
        end
      end
    end
  end

  task automatic beat(input logic [24:0] ins, input logic [2:0] src, input logic [7:0] tag);
    int   n;
    logic took;
    n = 0;
    took = 0;
    in_valid = 1; in_instr = ins; in_imm_src = src; in_tag = tag;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready32;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    if (!took) begin
      checks++; errors++;
      $display("FAIL beat_timeout tag=%h actual=stalled required=accepted", tag);
    end
  endtask

  // Sends one beat with out_ready=1 and pins the next-cycle outputs to literals.
  task automatic directed(input logic [24:0] ins, input logic [2:0] src, input logic [7:0] tag,
                          input logic [31:0] e32, input logic [63:0] e64, input logic eerr);
    beat(ins, src, tag);
    @(negedge clk);
    chk("lit_valid", 64'(out_valid32 & out_valid64), 64'd1);
    chk("lit_imm32", 64'(out_imm32), 64'(e32));
    chk("lit_imm64", out_imm64, e64);
    chk("lit_err",   64'({out_err32, out_err64}), eerr ? 64'd3 : 64'd0);
    chk("lit_tag",   64'(out_tag32), 64'(tag));
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, n0;
    rst_n = 0; in_valid = 0; in_instr = '0; in_imm_src = '0; in_tag = '0; out_ready = 1;

    chk("model_addi",  64'(model(25'h1FFE001, 3'd0, 64)), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_lui",   64'(model(25'h12468A5, 3'd3, 64)), 64'hFFFF_FFFF_9234_5000);
    chk("model_sh32",  64'(model(25'h007E000, 3'd6, 32)), 64'h1F);
    chk("model_jal",   64'(model(25'h1FFBFE0, 3'd4, 64)), 64'hFFFF_FFFF_FFFF_FFFC);

    repeat (2) @(posedge clk);
    #1 rst_n = 1; mon_en = 1;
    @(negedge clk);
    chk("rst_valid", 64'({out_valid32, out_valid64}), 64'd0);
    chk("rst_imm",   out_imm64 | 64'(out_imm32), 64'd0);
    chk("rst_err_tag", 64'({out_err32, out_err64, out_tag32, out_tag64}), 64'd0);
    chk("rst_ready", 64'({in_ready32, in_ready64}), 64'd3);
    @(posedge clk); #1;

    directed(25'h1FFE001, 3'd0, 8'h5A, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    directed(25'h02468A5, 3'd3, 8'h11, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    directed(25'h12468A5, 3'd3, 8'h12, 32'h9234_5000, 64'hFFFF_FFFF_9234_5000, 1'b0);
    directed(25'h007E000, 3'd6, 8'h13, 32'h0000_001F, 64'h3F, 1'b0);
    directed(25'h0001F00, 3'd5, 8'h14, 32'h0000_001F, 64'h1F, 1'b0);
    directed(25'h1FFE001, 3'd7, 8'h15, 32'h0, 64'h0, 1'b1);
    directed(25'h1FFBFE0, 3'd4, 8'h16, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    directed(25'h0004108, 3'd2, 8'h17, 32'h0000_0008, 64'h8, 1'b0);
    directed(25'h1FC4158, 3'd1, 8'h18, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);

    // Backpressure: two beats fill the buffer, the rest wait for out_ready.
    out_ready = 0;
    seen.delete();
    fork
      begin
        for (int t = 1; t <= 4; t++) beat(25'($urandom()), 3'(t), 8'(t));
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_ready_low", 64'({in_ready32, in_ready64}), 64'd0);
        chk("bp_head_tag",  64'(out_tag32), 64'd1);
        @(posedge clk); #1 out_ready = 1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_count", 64'(seen.size()), 64'd4);
    for (int t = 0; t < 4 && t < seen.size(); t++) chk("bp_order", 64'(seen[t]), 64'(t + 1));

    // Throughput: 100 back-to-back beats drain in 101 cycles.
    c0 = cyc; n0 = n_out; thr_mode = 1; rdy_low = 0;
    for (int i = 0; i < 100; i++) beat(25'($urandom()), 3'(i % 8), 8'(i));
    @(posedge clk); #1;
    thr_mode = 0;
    chk("thr_cycles", 64'(cyc - c0), 64'd101);
    chk("thr_beats",  64'(n_out - n0), 64'd100);
    chk("thr_ready",  64'(rdy_low), 64'd0);

    // Reset with two beats buffered.
    out_ready = 0;
    beat(25'h1FFE001, 3'd0, 8'hA1);
    beat(25'h02468A5, 3'd3, 8'hA2);
    rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("mid_rst_valid", 64'({out_valid32, out_valid64}), 64'd0);
    chk("mid_rst_imm",   out_imm64 | 64'(out_imm32), 64'd0);
    chk("mid_rst_ready", 64'({in_ready32, in_ready64}), 64'd3);
    @(posedge clk); #1 out_ready = 1;
    directed(25'h12468A5, 3'd3, 8'hB1, 32'h9234_5000, 64'hFFFF_FFFF_9234_5000, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("end_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
